// File: rtl/d_input_debounce.sv
// d_input_debounce: 2-flop synchroniser plus settle-count debouncer that drives the d_latch data input.
// Optional rise/fall pulses are built only when DEBOUNCE_EDGE_OUT_EN is defined.
module d_input_debounce #(
    parameter int   CNT_W         = 16,
    parameter int   STABLE_CYCLES = 1000,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din_raw,
    output logic d,
    output logic busy,
    output logic rise,
    output logic fall
);
    if (STABLE_CYCLES < 2 || longint'(STABLE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_param
        $error("d_input_debounce: STABLE_CYCLES out of range 2..2**CNT_W-1");
    end

    localparam logic [0:0]       STABLE = 1'b0;
    localparam logic [0:0]       SETTLE = 1'b1;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(STABLE_CYCLES - 1);

    logic             sync0_q, sync1_q;
    logic             d_q, d_d;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        d_d     = d_q;
        if (state_q == STABLE) begin
            if (sync1_q != d_q) begin
                state_d = SETTLE;
                cnt_d   = CNT_W'(1);
            end
        end else if (sync1_q == d_q) begin
            state_d = STABLE;
        end else if (cnt_q == LAST) begin
            d_d     = sync1_q;
            state_d = STABLE;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q <= RST_VAL;
            sync1_q <= RST_VAL;
            d_q     <= RST_VAL;
            state_q <= STABLE;
            cnt_q   <= '0;
        end else begin
            sync0_q <= din_raw;
            sync1_q <= sync0_q;
            d_q     <= d_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign d    = d_q;
    assign busy = (state_q == SETTLE);

`ifdef DEBOUNCE_EDGE_OUT_EN
    logic rise_q, fall_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= d_d & ~d_q;
            fall_q <= ~d_d & d_q;
        end
    end
    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif
endmodule

// File: tb/tb_d_input_debounce.sv
// tb_d_input_debounce: scoreboard bench; stimulus pushes predicted outputs, a monitor pops and compares each cycle.
module tb_d_input_debounce;
    localparam int   SC = 4;
    localparam logic RV = 1'b0;
`ifdef DEBOUNCE_EDGE_OUT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    typedef struct packed {
        logic d;
        logic busy;
        logic rise;
        logic fall;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_raw = 1'b0;
    logic d, busy, rise, fall;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    // model state: the two most recent raw samples, the current level, and how long
    // the oldest-but-one sample has disagreed with that level
    logic m_s0 = RV, m_s1 = RV, m_d = RV;
    int   m_run = 0;

    d_input_debounce #(.CNT_W(16), .STABLE_CYCLES(SC), .RST_VAL(RV)) dut (
        .clk(clk), .rst(rst), .din_raw(din_raw),
        .d(d), .busy(busy), .rise(rise), .fall(fall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act == want) passed++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, want);
    endtask

    task automatic step(input logic r, input logic x);
        exp_t e;
        logic s, old;
        @(negedge clk);
        rst     = r;
        din_raw = x;
        if (r) begin
            m_s0 = RV; m_s1 = RV; m_d = RV; m_run = 0;
            e = '{RV, 1'b0, 1'b0, 1'b0};
        end else begin
            s     = m_s1;
            old   = m_d;
            m_s1  = m_s0;
            m_s0  = x;
            m_run = (s != m_d) ? m_run + 1 : 0;
            if (m_run == SC) begin
                m_d   = s;
                m_run = 0;
            end
            e.d    = m_d;
            e.busy = (m_run != 0);
            e.rise = EDGE_EN && m_d && !old;
            e.fall = EDGE_EN && !m_d && old;
        end
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic r, input logic x, input int n);
        for (int i = 0; i < n; i++) step(r, x);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("d", int'(d), int'(e.d));
                chk("busy", int'(busy), int'(e.busy));
                chk("rise", int'(rise), int'(e.rise));
                chk("fall", int'(fall), int'(e.fall));
            end
        end
    end

    initial begin : stim
        int lat;
        hold(1'b1, 1'b1, 3);
        hold(1'b0, 1'b0, 8);
        // clean rise: latency from the sampling edge to d going high
        step(1'b0, 1'b1);
        lat = 0;
        do begin
            step(1'b0, 1'b1);
            lat++;
        end while (d !== 1'b1 && lat < 20);
        chk("latency", lat - 1, SC + 1);
        hold(1'b0, 1'b1, 6);
        hold(1'b0, 1'b0, 10);
        // short pulse rejected
        hold(1'b0, 1'b1, 2);
        hold(1'b0, 1'b0, 10);
        // bounce 1,0,1 then hold
        step(1'b0, 1'b1); step(1'b0, 1'b0);
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 10);
        // reset while a change is being timed
        hold(1'b0, 1'b1, 4);
        step(1'b1, 1'b1);
        hold(1'b0, 1'b1, 10);
        for (int seg = 0; seg < 500; seg++) begin
            if ($urandom_range(0, 39) == 0) hold(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            else hold(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 2 * SC + 2));
        end
        hold(1'b0, 1'b0, 12);
        repeat (3) @(negedge clk);
        chk("drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
